// File: rtl/dualmem_arbiter_if.sv
// Requester-side bundle of the dualmem_arbiter: request/write inputs, grant and read return.
// The lock vector exists only when DMEM_ARB_LOCK_EN is defined.
interface dualmem_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 11
);
  logic [NREQ-1:0]    req;
  logic [NREQ*8-1:0]  we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*64-1:0] wdata;
`ifdef DMEM_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [63:0]        rdata;

  modport master (
`ifdef DMEM_ARB_LOCK_EN
    output lock,
`endif
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
`ifdef DMEM_ARB_LOCK_EN
    input  lock,
`endif
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dualmem_arbiter.sv
// Round-robin arbiter and zero-fill initialiser for one port of a 2K x 64 byte-enable RAM.
// Optional grant locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dualmem_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 11,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  dualmem_arbiter_if.slave bus,
  output logic             init_done,
  output logic             mem_en,
  output logic [7:0]       mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata
);
  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [AW-1:0]   cnt_r;
  logic [IW-1:0]   rr_r;
  logic [IW-1:0]   rr_next_s;
  logic [IW-1:0]   idx_s;
  logic [IW-1:0]   win_s;
  logic            win_valid_s;
  logic            init_done_r;
  logic [NREQ-1:0] gnt_s;
  logic [NREQ-1:0] rvalid_r;
  logic [NREQ-1:0] rvalid_next_s;
`ifdef DMEM_ARB_LOCK_EN
  logic            hold_r;
  logic            hold_next_s;
`endif

  // Winner search: first active request from rr+1 upward, lock holder takes precedence
  always_comb begin
    win_valid_s = 1'b0;
    win_s       = rr_r;
    idx_s       = rr_r;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IW'((int'(rr_r) + k) % NREQ);
      if (!win_valid_s && bus.req[idx_s]) begin
        win_valid_s = 1'b1;
        win_s       = idx_s;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
`ifdef DMEM_ARB_LOCK_EN
    if (hold_r && bus.req[rr_r] && bus.lock[rr_r]) begin
      win_valid_s = 1'b1;
      win_s       = rr_r;
    end else begin
      win_valid_s = win_valid_s;
    end
`endif
  end

  // Next state, grant and RAM port drive; everything is forced quiet while rst is high
  always_comb begin
    state_next_s  = state_r;
    rr_next_s     = rr_r;
    gnt_s         = {NREQ{1'b0}};
    rvalid_next_s = {NREQ{1'b0}};
    mem_en        = 1'b0;
    mem_we        = 8'h00;
    mem_addr      = {AW{1'b0}};
    mem_wdata     = 64'h0;
`ifdef DMEM_ARB_LOCK_EN
    hold_next_s   = 1'b0;
`endif
    if (rst) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_INIT: begin
          mem_en   = 1'b1;
          mem_we   = 8'hFF;
          mem_addr = cnt_r;
          if (cnt_r == AW'(DEPTH - 1)) begin
            state_next_s = ST_ARB;
          end else begin
            state_next_s = ST_INIT;
          end
        end
        ST_ARB: begin
          if (win_valid_s) begin
            gnt_s     = NREQ'(1'b1) << win_s;
            rr_next_s = win_s;
            mem_en    = 1'b1;
            mem_we    = 8'(bus.we >> (8 * int'(win_s)));
            mem_addr  = AW'(bus.addr >> (AW * int'(win_s)));
            mem_wdata = 64'(bus.wdata >> (64 * int'(win_s)));
            if (mem_we == 8'h00) begin
              rvalid_next_s = gnt_s;
            end else begin
              rvalid_next_s = {NREQ{1'b0}};
            end
`ifdef DMEM_ARB_LOCK_EN
            hold_next_s = bus.lock[win_s];
`endif
          end else begin
            rr_next_s = rr_r;
          end
        end
        default: begin
          state_next_s = ST_ARB;
        end
      endcase
    end
  end

  // State, sweep counter, rotation pointer and read-return registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET != 0) begin
        state_r <= ST_INIT;
      end else begin
        state_r <= ST_ARB;
      end
      cnt_r       <= {AW{1'b0}};
      rr_r        <= IW'(NREQ - 1);
      init_done_r <= 1'b0;
      rvalid_r    <= {NREQ{1'b0}};
`ifdef DMEM_ARB_LOCK_EN
      hold_r      <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_INIT) begin
        cnt_r <= cnt_r + AW'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      rr_r        <= rr_next_s;
      init_done_r <= init_done_r | (state_next_s == ST_ARB);
      rvalid_r    <= rvalid_next_s;
`ifdef DMEM_ARB_LOCK_EN
      hold_r      <= hold_next_s;
`endif
    end
  end

  assign bus.gnt    = gnt_s;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = mem_rdata;
  assign init_done  = init_done_r;

endmodule

// File: tb/tb_dualmem_arbiter.sv
// Self-checking bench for dualmem_arbiter: behavioural RAM, spec-level reference model
// checked every cycle, plus directed transactions with literal expectations.
module tb_dualmem_arbiter;
  localparam int NREQ  = 2;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          mem_en;
  logic [7:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata = 64'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dualmem_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();

  dualmem_arbiter #(
    .NREQ(NREQ), .AW(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .init_done(init_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM with byte enables and 1-cycle read latency, preloaded with junk
  logic [63:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 64'hA5A5_5A5A_C3C3_3C3C ^ 64'(i);
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 8; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep counter, last winner, shadow memory, pending read
  logic [63:0]     sh [DEPTH];
  int              m_cnt, m_last;
  bit              m_init, m_done, m_hold;
  logic [NREQ-1:0] m_rv;
  logic [63:0]     m_rexp;

  initial begin
    forever begin : mdl
      int w, idx;
      logic [NREQ-1:0] eg, nrv;
      logic [7:0]      ew;
      logic [AW-1:0]   ea;
      logic [63:0]     ed;
      bit              een;
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_init_done", init_done, 0);
        m_cnt = 0; m_init = 1; m_last = NREQ - 1; m_done = 0; m_rv = '0; m_hold = 0;
      end else begin
        eg = '0; nrv = '0; ew = 8'h00; ea = '0; ed = 64'h0; een = 0;
        chk("init_done", init_done, m_done);
        chk("rvalid", bus.rvalid, m_rv);
        if (m_rv != 0) chk("rdata", bus.rdata, m_rexp);
        if (m_init) begin
          een = 1; ew = 8'hFF; ea = AW'(m_cnt);
          sh[m_cnt] = 64'h0;
          m_cnt++;
          if (m_cnt == DEPTH) begin m_init = 0; m_done = 1; end
        end else begin
          w = -1;
          for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (w < 0 && ((bus.req >> idx) & 1) != 0) w = idx;
          end
`ifdef DMEM_ARB_LOCK_EN
          if (m_hold && ((bus.req >> m_last) & 1) != 0 && ((bus.lock >> m_last) & 1) != 0)
            w = m_last;
          m_hold = (w >= 0) && (((bus.lock >> w) & 1) != 0);
`endif
          if (w >= 0) begin
            een = 1;
            eg  = NREQ'(1) << w;
            ew  = 8'(bus.we >> (8 * w));
            ea  = AW'(bus.addr >> (AW * w));
            ed  = 64'(bus.wdata >> (64 * w));
            if (ew == 8'h00) begin
              nrv    = eg;
              m_rexp = sh[ea];
            end else begin
              for (int b = 0; b < 8; b++) if (ew[b]) sh[ea][b*8 +: 8] = ed[b*8 +: 8];
            end
            m_last = w;
          end
        end
        chk("gnt", bus.gnt, eg);
        chk("mem_en", mem_en, een);
        chk("mem_we", mem_we, ew);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        m_rv = nrv;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated access by requester i; returns read data seen with rvalid
  task automatic do_access(input int i, input logic [7:0] w, input logic [AW-1:0] a,
                           input logic [63:0] d, output logic [63:0] rd);
    bit got = 0;
    int t;
    bus.req   = NREQ'(1) << i;
    bus.we    = (NREQ*8)'(w) << (8 * i);
    bus.addr  = (NREQ*AW)'(a) << (AW * i);
    bus.wdata = (NREQ*64)'(d) << (64 * i);
    rd = 64'hx;
    for (t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      if (bus.gnt == (NREQ'(1) << i)) got = 1;
      else step();
    end
    chk("gnt_seen", got, 1);
    chk("gnt_same_cycle", t, 1);
    step();
    bus.req = '0; bus.we = '0;
    if (got) begin
      @(negedge clk);
      chk("rvalid_latency", bus.rvalid, (w == 8'h00) ? (NREQ'(1) << i) : '0);
      rd = bus.rdata;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    bit found;
    rst = 1; bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    bus.lock = '0;
`endif
    @(negedge clk);
    chk("reset_init_done", init_done, 0);
    step();
    rst = 0; bus.req = 2'b11;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("sweep_first_addr", mem_addr, 0);
        chk("sweep_we", mem_we, 8'hFF);
      end
      if (c <= DEPTH) chk("sweep_no_gnt", bus.gnt, 0);
      if (c == DEPTH) begin
        chk("sweep_last_addr", mem_addr, 11'd2047);
        chk("sweep_done_late", init_done, 0);
      end
      if (c == DEPTH + 1) begin
        chk("sweep_done", init_done, 1);
        chk("first_gnt_req0", bus.gnt, 2'b01);
      end
      step();
    end
    bus.req = '0;
    step();

    do_access(0, 8'h00, 11'd0, 64'h0, rd);    chk("zero_addr0", rd, 64'h0);
    do_access(1, 8'h00, 11'd5, 64'h0, rd);    chk("zero_addr5", rd, 64'h0);
    do_access(0, 8'h00, 11'd2047, 64'h0, rd); chk("zero_addr2047", rd, 64'h0);
    do_access(0, 8'hFF, 11'h123, 64'hDEADBEEF_01234567, rd);
    do_access(0, 8'h00, 11'h123, 64'h0, rd);  chk("read_back", rd, 64'hDEADBEEF_01234567);
    do_access(1, 8'hFF, 11'd7, 64'hFFFFFFFF_FFFFFFFF, rd);
    do_access(1, 8'h0F, 11'd7, 64'h0, rd);
    do_access(1, 8'h00, 11'd7, 64'h0, rd);    chk("byte_enable", rd, 64'hFFFFFFFF_00000000);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_mem_en", mem_en, 0);
      chk("idle_gnt", bus.gnt, 0);
      step();
    end

    // Reset mid-sweep at address 900
    rst = 1;
    step();
    rst = 0;
    found = 0;
    for (int t = 0; t < DEPTH && !found; t++) begin
      @(negedge clk);
      if (mem_en && mem_addr == 11'd900) found = 1;
      step();
    end
    chk("reach_addr900", found, 1);
    rst = 1;
    @(negedge clk);
    chk("midsweep_done_clr", init_done, 0);
    step();
    rst = 0;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      @(negedge clk);
      if (c == 1) chk("restart_addr0", mem_addr, 0);
      if (c <= DEPTH) chk("restart_not_done", init_done, 0);
      if (c == DEPTH + 1) chk("restart_done", init_done, 1);
      step();
    end

    // Contention from fresh reset: strict rotation
    bus.req = 2'b11; bus.we = '0; bus.addr = {11'd9, 11'd8};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rotation", bus.gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    bus.req = '0;
    step();

`ifdef DMEM_ARB_LOCK_EN
    bus.req = 2'b11; bus.lock = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lock_hold", bus.gnt, 2'b01);
      step();
    end
    bus.lock = 2'b00;
    @(negedge clk);
    chk("lock_release", bus.gnt, 2'b10);
    step();
    bus.req = '0;
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dualmem_arbiter.md
Name: dualmem_arbiter

Overview:
- Round-robin arbiter and initialiser for one port of a 2K x 64 synchronous dual-port RAM with byte write enables.
- Shares that single port between NREQ requesters, for example a CPU data path, a DMA engine and a debug bridge.
- Optionally zero-fills the whole RAM after reset.
- Returns read data with 1-cycle latency and a per-requester rvalid.

Parameters:
- NREQ, 2, number of requesters (legal range 2..4).
- AW, 11, word address width.
- DEPTH, 2048, words cleared by the init sweep (must equal 2**AW).
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep after reset; 0 = go straight to ARB.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester access request; level, held until granted.
- we  in  NREQ*8  per-requester byte write enables, slice i = [i*8 +: 8]; all-zero means read.
- addr  in  NREQ*AW  per-requester word address.
- wdata  in  NREQ*64  per-requester write data.
- gnt  out  NREQ  one-hot grant, combinational; the access completes in that cycle.
- rvalid  out  NREQ  registered; asserted the cycle after a granted read.
- rdata  out  64  shared read data, passthrough of mem_rdata.
- init_done  out  1  high once the sweep has completed, or immediately after reset when CLEAR_ON_RESET=0.
- mem_en  out  1  RAM port enable.
- mem_we  out  8  RAM byte write enables.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  64  RAM write data.
- mem_rdata  in  64  RAM read data, valid 1 cycle after mem_en.

Behaviour:
- Reset values (async, while rst=1): state=INIT if CLEAR_ON_RESET else ARB; init counter=0; rr pointer=NREQ-1 (so requester 0 wins first); rvalid=0; init_done=0.
  - Combinational outputs are 0 during reset: gnt, mem_en, mem_we, mem_addr, mem_wdata.
- State INIT:
  - mem_en=1, mem_we=8'hFF, mem_wdata=0, mem_addr=counter; gnt=0 whatever req shows.
  - Counter increments every cycle.
  - On the cycle with counter=DEPTH-1: next state=ARB, init_done goes 1 on the following edge.
  - Sweep takes exactly DEPTH cycles.
- State ARB, grant selection:
  - Winner is the first requester with req=1 searching from rr+1 upward, modulo NREQ.
  - gnt is one-hot to that requester, or 0 if no req.
  - On a grant, rr is updated to the winner index. rr is unchanged if there was no grant.
- State ARB, RAM drive:
  - mem_en = |gnt.
  - mem_we, mem_addr, mem_wdata are muxed from the winner.
  - When idle: mem_we=0, mem_addr=0, mem_wdata=0.
- Read return:
  - rvalid[i] <= gnt[i] & (we slice i == 0).
  - rdata = mem_rdata. It is meaningful only when some rvalid bit is high.
- Writes: no response beyond gnt.
- Throughput and fairness:
  - One access per cycle, back-to-back.
  - A requester holding req continuously is granted at least once every NREQ cycles.
- Simultaneous requests from all requesters: strict rotation 0,1,..,NREQ-1,0,...
- Reset mid-sweep: counter returns to 0 and init_done to 0; the sweep restarts from address 0 after release.
- Reset with a read in flight: rvalid is cleared and the data is dropped.
- A requester that deasserts req before being granted is simply not granted. No error is raised.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro:
  - Extra input port lock, NREQ bits.
  - If requester i is granted in a cycle with lock[i]=1, and next cycle req[i]=1, it is granted again regardless of round-robin. The rr pointer stays at i.
  - The lock ends the first cycle req[i]=0 or lock[i]=0; normal rotation resumes from i+1.
  - lock has no effect without a grant.
- Without the macro: the lock port does not exist; pure round-robin.

Test Plan:
- Reset/init, CLEAR_ON_RESET=1:
  - Assert rst, release, req=2'b11 throughout.
  - Expect gnt=0 for 2048 cycles, mem_we=8'hFF, mem_addr sweeping 0..2047, init_done=1 from cycle 2049.
  - Reads of addresses 0, 5 and 2047 return 64'h0.
- Read latency:
  - Requester 0 writes 64'hDEADBEEF_01234567 to addr 0x123 with we=8'hFF, then reads 0x123.
  - Expect gnt[0] the same cycle, rvalid[0]=1 exactly one cycle later, rdata=64'hDEADBEEF_01234567.
- Byte enables:
  - Write 64'hFFFF..FF to addr 7, then write 64'h0 with we=8'h0F, then read addr 7.
  - Expect 64'hFFFFFFFF_00000000.
- Contention: req=2'b11 held for 6 cycles from reset (after init) -> gnt sequence 01,10,01,10,01,10.
- Idle and reset mid-operation:
  - No req -> mem_en=0, gnt=0, rr unchanged.
  - rst pulsed mid-sweep at addr 900 -> sweep restarts at 0, init_done=0 until a full 2048-cycle sweep completes.
- Lock, with DMEM_ARB_LOCK_EN:
  - req=2'b11, lock=2'b01 for 4 cycles -> gnt=01 on all 4 cycles.
  - Drop lock -> next gnt=10.
